// File: rtl/button_event_detector.sv
// Turns a debounced switch level into press / short-release / long / long-release pulses plus a held level.
// Define BUTTON_EVENT_AUTO_REPEAT_EN to enable periodic o_Repeat pulses while a long press is held.
module button_event_detector #(
  parameter int c_LONG_CYCLES   = 100000000,
  parameter int c_REPEAT_CYCLES = 20000000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Press,
  output logic o_Short_Rel,
  output logic o_Long,
  output logic o_Long_Rel,
  output logic o_Repeat,
  output logic o_Held
);

  localparam int c_CNT_MAX = (c_LONG_CYCLES > c_REPEAT_CYCLES) ? c_LONG_CYCLES : c_REPEAT_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;
  localparam logic [c_CNT_W-1:0] c_LONG_LAST = c_CNT_W'(c_LONG_CYCLES - 1);
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
  localparam logic [c_CNT_W-1:0] c_REPEAT_LAST = c_CNT_W'(c_REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
  } state_t;

  state_t state, state_next;
  logic [c_CNT_W-1:0] cnt, cnt_next;
  logic press_next, short_rel_next, long_next, long_rel_next;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
  logic repeat_next;
`endif

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    press_next     = 1'b0;
    short_rel_next = 1'b0;
    long_next      = 1'b0;
    long_rel_next  = 1'b0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    repeat_next    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (i_Switch) begin
          state_next = PRESSED;
          press_next = 1'b1;
          cnt_next   = '0;
        end
      end
      PRESSED: begin
        // A release on the threshold edge is reported as short, never long
        if (!i_Switch) begin
          state_next     = IDLE;
          short_rel_next = 1'b1;
          cnt_next       = '0;
        end else if (cnt == c_LONG_LAST) begin
          state_next = LONG;
          long_next  = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      LONG: begin
        if (!i_Switch) begin
          state_next    = IDLE;
          long_rel_next = 1'b1;
          cnt_next      = '0;
        end else begin
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
          if (cnt == c_REPEAT_LAST) begin
            repeat_next = 1'b1;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
`else
          cnt_next = '0;
`endif
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      cnt         <= '0;
      o_Press     <= 1'b0;
      o_Short_Rel <= 1'b0;
      o_Long      <= 1'b0;
      o_Long_Rel  <= 1'b0;
      o_Held      <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      o_Press     <= press_next;
      o_Short_Rel <= short_rel_next;
      o_Long      <= long_next;
      o_Long_Rel  <= long_rel_next;
      o_Held      <= (state_next != IDLE);
    end
  end

`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Repeat <= 1'b0;
    end else begin
      o_Repeat <= repeat_next;
    end
  end
`else
  assign o_Repeat = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_detector.sv
// Self-checking bench for button_event_detector: timing model keyed on press time plus directed literal checks.
module tb_button_event_detector;

  localparam int LONG = 10;
  localparam int REP  = 4;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic i_Clk    = 1'b0;
  logic i_Rst_L  = 1'b1;
  logic i_Switch = 1'b0;
  logic o_Press, o_Short_Rel, o_Long, o_Long_Rel, o_Repeat, o_Held;

  always #5 i_Clk = ~i_Clk;

  button_event_detector #(
    .c_LONG_CYCLES  (LONG),
    .c_REPEAT_CYCLES(REP)
  ) dut (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Switch   (i_Switch),
    .o_Press    (o_Press),
    .o_Short_Rel(o_Short_Rel),
    .o_Long     (o_Long),
    .o_Long_Rel (o_Long_Rel),
    .o_Repeat   (o_Repeat),
    .o_Held     (o_Held)
  );

  // Model: events depend only on how many edges have elapsed since the press edge
  logic m_hold = 1'b0, m_press = 1'b0, m_short = 1'b0, m_long = 1'b0, m_lrel = 1'b0, m_rep = 1'b0;
  int   m_cyc  = 0;
  int   m_pcyc = 0;

  always @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      m_hold <= 1'b0; m_press <= 1'b0; m_short <= 1'b0;
      m_long <= 1'b0; m_lrel  <= 1'b0; m_rep   <= 1'b0;
      m_cyc  <= 0;    m_pcyc  <= 0;
    end else begin
      m_cyc   <= m_cyc + 1;
      m_press <= 1'b0; m_short <= 1'b0; m_long <= 1'b0;
      m_lrel  <= 1'b0; m_rep   <= 1'b0;
      if (!m_hold) begin
        if (i_Switch) begin
          m_hold  <= 1'b1;
          m_press <= 1'b1;
          m_pcyc  <= m_cyc;
        end
      end else if (!i_Switch) begin
        m_hold <= 1'b0;
        if (m_cyc - m_pcyc <= LONG) m_short <= 1'b1;
        else                        m_lrel  <= 1'b1;
      end else begin
        if (m_cyc - m_pcyc == LONG) m_long <= 1'b1;
        if (REP_EN && (m_cyc - m_pcyc > LONG) && (((m_cyc - m_pcyc - LONG) % REP) == 0))
          m_rep <= 1'b1;
      end
    end
  end

  int chk_cnt = 0;
  int pass_cnt = 0;
  int tb_cyc = 0;
  int n_press = 0, n_short = 0, n_long = 0, n_lrel = 0, n_rep = 0, n_held = 0;
  int t_press = 0, t_short = 0, t_long = 0, t_rep_first = 0, t_rep_last = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, tb_cyc);
  endtask

  // Per-cycle compare against the model and event bookkeeping, sampled on the falling edge
  task automatic stepCycle();
    @(negedge i_Clk);
    tb_cyc++;
    checkOutput("press",     int'(o_Press),     int'(m_press));
    checkOutput("short_rel", int'(o_Short_Rel), int'(m_short));
    checkOutput("long",      int'(o_Long),      int'(m_long));
    checkOutput("long_rel",  int'(o_Long_Rel),  int'(m_lrel));
    checkOutput("repeat",    int'(o_Repeat),    int'(m_rep));
    checkOutput("held",      int'(o_Held),      int'(m_hold));
    checkOutput("one_pulse", int'($countones({o_Press, o_Short_Rel, o_Long, o_Long_Rel, o_Repeat}) <= 1), 1);
    if (o_Press)     begin n_press++; t_press = tb_cyc; end
    if (o_Short_Rel) begin n_short++; t_short = tb_cyc; end
    if (o_Long)      begin n_long++;  t_long  = tb_cyc; end
    if (o_Long_Rel)  n_lrel++;
    if (o_Repeat) begin
      n_rep++;
      if (t_rep_first <= t_long) t_rep_first = tb_cyc;
      t_rep_last = tb_cyc;
    end
    if (o_Held) n_held++;
  endtask

  task automatic applyStimulus(input logic sw, input int n);
    for (int i = 0; i < n; i++) begin
      stepCycle();
      i_Switch = sw;
    end
  endtask

  int s_press, s_short, s_long, s_lrel, s_rep, s_held;

  task automatic snap();
    s_press = n_press; s_short = n_short; s_long = n_long;
    s_lrel  = n_lrel;  s_rep   = n_rep;   s_held = n_held;
  endtask

  initial begin
    $display("[TB] start");
    #1 i_Rst_L = 1'b0;
    #1;
    checkOutput("reset_held",  int'(o_Held),  0);
    checkOutput("reset_press", int'(o_Press), 0);
    applyStimulus(1'b0, 2);
    i_Rst_L = 1'b1;

    // Idle after reset: nothing happens for 20 cycles
    snap();
    applyStimulus(1'b0, 20);
    checkOutput("idle_held_cycles", n_held - s_held, 0);
    checkOutput("idle_presses",     n_press - s_press, 0);

    // Short press of 5 samples
    snap();
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 3);
    checkOutput("short_presses",   n_press - s_press, 1);
    checkOutput("short_releases",  n_short - s_short, 1);
    checkOutput("short_longs",     n_long - s_long, 0);
    checkOutput("short_held_cyc",  n_held - s_held, 5);
    checkOutput("short_rel_delay", t_short - t_press, 5);

    // Long press of 30 samples
    snap();
    applyStimulus(1'b1, 30);
    applyStimulus(1'b0, 3);
    checkOutput("long_count",     n_long - s_long, 1);
    checkOutput("long_delay",     t_long - t_press, 10);
    checkOutput("long_releases",  n_lrel - s_lrel, 1);
    checkOutput("long_no_short",  n_short - s_short, 0);
    checkOutput("long_held_cyc",  n_held - s_held, 30);
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    checkOutput("repeat_count",   n_rep - s_rep, 4);
    checkOutput("repeat_first",   t_rep_first - t_long, 4);
    checkOutput("repeat_last",    t_rep_last - t_long, 16);
`else
    checkOutput("repeat_count",   n_rep - s_rep, 0);
`endif

    // Release on exactly the threshold edge
    snap();
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 3);
    checkOutput("thresh_short", n_short - s_short, 1);
    checkOutput("thresh_long",  n_long - s_long, 0);

    // Press accepted on the edge right after a release
    snap();
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 3);
    checkOutput("b2b_presses", n_press - s_press, 2);
    checkOutput("b2b_shorts",  n_short - s_short, 2);

    // Reset mid-hold in LONG, then release reset with the switch still pressed
    snap();
    applyStimulus(1'b1, 15);
    stepCycle();
    checkOutput("pre_reset_held", int'(o_Held), 1);
    #2 i_Rst_L = 1'b0;
    #1;
    checkOutput("async_held",     int'(o_Held), 0);
    checkOutput("async_long_rel", int'(o_Long_Rel), 0);
    checkOutput("async_repeat",   int'(o_Repeat), 0);
    applyStimulus(1'b1, 2);
    i_Rst_L = 1'b1;
    stepCycle();
    checkOutput("press_after_reset", int'(o_Press), 1);
    applyStimulus(1'b0, 3);
    checkOutput("abort_no_long_rel", n_lrel - s_lrel, 0);
    checkOutput("abort_presses",     n_press - s_press, 2);

    $display("[TB] %0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
